// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg : frame geometry, sequencer state type and default FFT latency
// Revision: 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int N_POINTS        = 16;
  localparam int ADDR_W          = 4;
  localparam int DATA_W          = 16;
  localparam int FFT_LAT_DEFAULT = 4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_ctrl : loads 16 samples into the FFT input RAM, waits for the
//                  transform to settle, then streams the 16 bins out.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int FFT_LAT = FFT_LAT_DEFAULT,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data_r,
  output logic [DATA_W-1:0] m_data_i,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata_r,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [7:0] FFT_LAT_L = 8'(FFT_LAT);
  localparam logic [1:0] RD_LAT_L  = 2'(RD_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [7:0]        wait_q, wait_d;
  logic [1:0]        lat_q, lat_d;
  logic              quiet_q, quiet_d;
  logic [DATA_W-1:0] dat_r_q, dat_r_d;
  logic [DATA_W-1:0] dat_i_q, dat_i_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              last_q, last_d;

  // quiet_q blocks RAM writes in the first cycle after reset is released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wait_q  <= '0;
      lat_q   <= '0;
      quiet_q <= 1'b1;
      dat_r_q <= '0;
      dat_i_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wait_q  <= wait_d;
      lat_q   <= lat_d;
      quiet_q <= quiet_d;
      dat_r_q <= dat_r_d;
      dat_i_q <= dat_i_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wait_d  = wait_q;
    lat_d   = lat_q;
    quiet_d = 1'b0;
    dat_r_d = dat_r_q;
    dat_i_d = dat_i_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_LOAD: begin
        if (s_valid && s_ready) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_IDX) begin
            state_d = ST_WAIT;
            wait_d  = FFT_LAT_L;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q <= 8'd1) begin
          state_d = ST_READ;
          rcnt_d  = '0;
          lat_d   = RD_LAT_L;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      // lat_q counts RD_LAT cycles after the read strobe, then the data is valid
      ST_READ: begin
        if (lat_q == 2'd0) begin
          dat_r_d = ram_rdata_r;
          dat_i_d = ram_rdata_i;
          idx_d   = rcnt_q;
          last_d  = (rcnt_q == LAST_IDX);
          state_d = ST_HOLD;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_HOLD: begin
        if (m_valid && m_ready) begin
          if (rcnt_q == LAST_IDX) begin
            rcnt_d  = '0;
            state_d = ST_LOAD;
          end else begin
            rcnt_d  = rcnt_q + 1'b1;
            lat_d   = RD_LAT_L;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready    = (state_q == ST_LOAD) && !rst && !quiet_q;
    m_valid    = (state_q == ST_HOLD) && !rst;
    ram_we     = s_valid && s_ready;
    ram_waddr  = ram_we ? wcnt_q : '0;
    ram_wdata  = ram_we ? s_data : '0;
    ram_re     = (state_q == ST_READ) && (lat_q == RD_LAT_L) && !rst;
    ram_raddr  = ram_re ? rcnt_q : '0;
    frame_done = m_valid && m_ready && last_q;
    busy       = (state_q != ST_LOAD) || (wcnt_q != '0);
  end

  assign m_data_r = dat_r_q;
  assign m_data_i = dat_i_q;
  assign m_index  = idx_q;
  assign m_last   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fft_frame_ctrl : randomized frame traffic against a RAM model and a
//                     frame-level reference of writes, reads and bins.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int FFT_LAT = 1;
  localparam int RD_LAT  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, m_valid, m_last, ram_we, ram_re, busy, frame_done;
  logic [DATA_W-1:0] m_data_r, m_data_i, ram_wdata, ram_rdata_r, ram_rdata_i;
  logic [ADDR_W-1:0] m_index, ram_waddr, ram_raddr;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.FFT_LAT(FFT_LAT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_r(m_data_r), .m_data_i(m_data_i),
    .m_index(m_index), .m_last(m_last),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr),
    .ram_rdata_r(ram_rdata_r), .ram_rdata_i(ram_rdata_i),
    .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output RAM model: data appears exactly RD_LAT cycles after the read strobe
  logic [DATA_W-1:0] mem_r [8][N_POINTS];
  logic [2:0]        rd_frame = '0;
  logic              pv [RD_LAT];
  logic [ADDR_W-1:0] pa [RD_LAT];
  always @(posedge clk) begin
    pv[0] <= ram_re;
    pa[0] <= ram_raddr;
    for (int k = 1; k < RD_LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end
  assign ram_rdata_r = (pv[RD_LAT-1] === 1'b1) ? mem_r[rd_frame][pa[RD_LAT-1]] : 16'hDEAD;
  assign ram_rdata_i = (pv[RD_LAT-1] === 1'b1) ? ~mem_r[rd_frame][pa[RD_LAT-1]] : 16'hBEEF;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } acc_t;
  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
    logic              last;
    logic              done;
    logic [2:0]        fr;
  } bin_t;

  acc_t              wq[$];
  acc_t              rq[$];
  bin_t              bq[$];
  logic [DATA_W-1:0] sq[$];

  int viol_strobe = 0, viol_sready = 0, viol_after = 0, viol_hold = 0, viol_lat = 0;
  int acc_in_frame = 0;
  bit in_load = 1'b1;
  bit pm_valid = 1'b0, pm_ready = 1'b0, pdone = 1'b0;
  logic [DATA_W-1:0] pr, pi;
  logic [ADDR_W-1:0] pidx;
  logic              plast;
  int last_re = -100;

  // Frame-level observer: logs every RAM access / bin and tracks protocol rules
  always @(negedge clk) begin
    if (rst) begin
      acc_in_frame = 0;
      in_load      = 1'b1;
      pm_valid     = 1'b0;
      pdone        = 1'b0;
    end else begin
      if (ram_we && ram_re) viol_strobe++;
      if (ram_we && !(s_valid && s_ready)) viol_strobe++;
      if (ram_re && !in_load && acc_in_frame != 0) viol_strobe++;
      if (s_ready && !in_load) viol_sready++;
      if (pdone && !s_ready) viol_after++;
      if (pm_valid && !pm_ready &&
          !(m_valid && m_index == pidx && m_data_r == pr && m_data_i == pi && m_last == plast))
        viol_hold++;
      if (m_valid && !pm_valid && (cyc - last_re != RD_LAT + 1)) viol_lat++;
      if (ram_we) begin
        if (!in_load) viol_strobe++;
        wq.push_back('{cyc, ram_waddr, ram_wdata});
        acc_in_frame++;
        if (acc_in_frame == N_POINTS) begin
          acc_in_frame = 0;
          in_load      = 1'b0;
        end
      end
      if (ram_re) begin
        if (in_load) viol_strobe++;
        rq.push_back('{cyc, ram_raddr, '0});
        last_re = cyc;
      end
      if (m_valid && m_ready)
        bq.push_back('{cyc, m_index, m_data_r, m_data_i, m_last, frame_done, rd_frame});
      if (frame_done) begin
        in_load  = 1'b1;
        rd_frame = rd_frame + 3'd1;
      end
      pm_valid = m_valid;
      pm_ready = m_ready;
      pdone    = frame_done;
      pr       = m_data_r;
      pi       = m_data_i;
      pidx     = m_index;
      plast    = m_last;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wq.delete();
    rq.delete();
    bq.delete();
    sq.delete();
  endtask

  // Drives nf frames; gap>0 offers a sample only every gap-th cycle
  task automatic run(input string tag, input int nf, input int gap, input bit rnd_ready,
                     input bit ramp);
    int sent_n = 0;
    int done_n = 0;
    int budget = 0;
    logic [DATA_W-1:0] cur;
    cur = ramp ? '0 : DATA_W'($urandom);
    while (done_n < nf && budget < 4000) begin
      @(posedge clk);
      #1;
      s_valid = (sent_n < N_POINTS * nf) && ((gap == 0) || (cyc % gap == 0));
      s_data  = cur;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        sq.push_back(cur);
        sent_n++;
        cur = ramp ? DATA_W'(sent_n) : DATA_W'($urandom);
      end
      if (frame_done) done_n++;
      budget++;
    end
    check({tag, " frames_done"}, 32'(done_n), 32'(nf));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_phase(input string tag, input int nf, input bit spacing);
    int n;
    logic [DATA_W-1:0] er, ei;
    check({tag, " n_writes"}, 32'(wq.size()), 32'(N_POINTS * nf));
    check({tag, " n_reads"},  32'(rq.size()), 32'(N_POINTS * nf));
    check({tag, " n_bins"},   32'(bq.size()), 32'(N_POINTS * nf));
    n = (wq.size() < sq.size()) ? wq.size() : sq.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s waddr[%0d]", tag, k), 32'(wq[k].a), 32'(k % N_POINTS));
      check($sformatf("%s wdata[%0d]", tag, k), 32'(wq[k].d), 32'(sq[k]));
    end
    for (int k = 0; k < rq.size(); k++)
      check($sformatf("%s raddr[%0d]", tag, k), 32'(rq[k].a), 32'(k % N_POINTS));
    for (int k = 0; k < bq.size(); k++) begin
      er = mem_r[bq[k].fr][k % N_POINTS];
      ei = ~er;
      check($sformatf("%s index[%0d]", tag, k), 32'(bq[k].idx), 32'(k % N_POINTS));
      check($sformatf("%s data_r[%0d]", tag, k), 32'(bq[k].r), 32'(er));
      check($sformatf("%s data_i[%0d]", tag, k), 32'(bq[k].i), 32'(ei));
      check($sformatf("%s last[%0d]", tag, k), 32'(bq[k].last), 32'(k % N_POINTS == N_POINTS - 1));
      check($sformatf("%s done[%0d]", tag, k), 32'(bq[k].done), 32'(k % N_POINTS == N_POINTS - 1));
      if (spacing && (k % N_POINTS) != 0)
        check($sformatf("%s bin_gap[%0d]", tag, k), 32'(bq[k].cyc - bq[k-1].cyc), 32'(RD_LAT + 2));
    end
    for (int f = 0; f < nf; f++)
      if (wq.size() > N_POINTS * f + N_POINTS - 1 && rq.size() > N_POINTS * f)
        check($sformatf("%s wait_lat[%0d]", tag, f),
              32'(rq[N_POINTS * f].cyc - wq[N_POINTS * f + N_POINTS - 1].cyc), 32'(FFT_LAT + 1));
    check({tag, " strobe_rules"}, 32'(viol_strobe), 32'd0);
    check({tag, " sready_in_busy"}, 32'(viol_sready), 32'd0);
    check({tag, " sready_after_done"}, 32'(viol_after), 32'd0);
    check({tag, " hold_stable"}, 32'(viol_hold), 32'd0);
    check({tag, " re_to_valid"}, 32'(viol_lat), 32'd0);
  endtask

  initial begin
    int guard;
    for (int a = 0; a < N_POINTS; a++) mem_r[0][a] = DATA_W'(a);
    for (int f = 1; f < 8; f++)
      for (int a = 0; a < N_POINTS; a++) mem_r[f][a] = DATA_W'($urandom);

    // reset behaviour
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst s_ready", 32'(s_ready), 32'd0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst ram_we", 32'(ram_we), 32'd0);
    check("post_rst ram_re", 32'(ram_re), 32'd0);
    s_valid = 1'b0;

    // ramp frame, m_ready held high
    clear_logs();
    run("ramp", 1, 0, 1'b0, 1'b1);
    check_phase("ramp", 1, 1'b1);

    // random backpressure
    clear_logs();
    run("bp", 1, 0, 1'b1, 1'b0);
    check_phase("bp", 1, 1'b0);

    // gapped input
    clear_logs();
    run("gap", 1, 3, 1'b1, 1'b0);
    check_phase("gap", 1, 1'b0);

    // reset while holding bin 7
    clear_logs();
    guard = 0;
    while (guard < 2000) begin
      @(posedge clk);
      #1;
      s_valid = (sq.size() < N_POINTS);
      s_data  = DATA_W'($urandom);
      m_ready = !(m_valid && m_index == 4'd7);
      @(negedge clk);
      if (s_valid && s_ready) sq.push_back(s_data);
      if (m_valid && m_index == 4'd7) break;
      guard++;
    end
    check("mid_rst reached_bin7", 32'(guard < 2000), 32'd1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    check("mid_rst m_valid", 32'(m_valid), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst ram_re", 32'(ram_re), 32'd0);
    check("mid_rst ram_we", 32'(ram_we), 32'd0);
    @(posedge clk);
    #1 s_valid = 1'b0;
    clear_logs();
    run("after_rst", 1, 0, 1'b1, 1'b0);
    check_phase("after_rst", 1, 1'b0);

    // two frames back to back
    clear_logs();
    run("b2b", 2, 0, 1'b0, 1'b0);
    check_phase("b2b", 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
